// File: rtl/oled_pkg.sv
// Shared definitions for the OLED frame sequencer: FSM states, the panel
// init command stream, the addressing command stream and the framebuffer size.
package oled_pkg;

  typedef enum logic [3:0] {
    RES_HOLD,
    RES_WAIT,
    INIT,
    IDLE,
    ADDR,
    FETCH,
    LOAD,
    SEND,
    DONE
  } state_e;

  localparam int INIT_LEN = 25;
  localparam int ADDR_LEN = 6;
  localparam int CMD_LEN  = INIT_LEN + ADDR_LEN;
  localparam int FB_BYTES = 1024;

  localparam logic [7:0] INIT_ROM [INIT_LEN] = '{
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
    8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
    8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
  };

  localparam logic [7:0] ADDR_SEQ [ADDR_LEN] = '{
    8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07
  };

endpackage

// File: rtl/oled_cmd_rom.sv
// Combinational command-byte lookup: indices 0..24 are the init stream,
// 25..30 the column/page addressing stream; anything beyond reads 0x00.
module oled_cmd_rom
  import oled_pkg::*;
(
  input  logic [4:0] idx,
  output logic [7:0] data
);

  logic [2:0] sub_idx;

  always_comb begin
    sub_idx = 3'(idx - 5'(INIT_LEN));
    data    = '0;
    if (idx < 5'(INIT_LEN)) begin
      data = INIT_ROM[idx];
    end else if (idx < 5'(CMD_LEN)) begin
      data = ADDR_SEQ[sub_idx];
    end
  end

endmodule

// File: rtl/oled_seq.sv
// OLED panel sequencer: hardware reset, init command stream, then on request
// one full frame (addressing commands + 1024 framebuffer bytes) per frame_req.
module oled_seq
  import oled_pkg::*;
#(
  parameter int unsigned RES_LOW_CYC  = 250,
  parameter int unsigned RES_WAIT_CYC = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_req,
  output logic [9:0] fb_addr,
  input  logic [7:0] fb_data,
  output logic [7:0] tx_byte,
  output logic       tx_dc,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       oled_res_n,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned CNT_MAX = (RES_LOW_CYC > RES_WAIT_CYC) ? RES_LOW_CYC : RES_WAIT_CYC;
  localparam int CNT_W = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       cmd_idx_q, cmd_idx_d;
  logic [9:0]       data_idx_q, data_idx_d;
  logic             pending_q, pending_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             tx_dc_q, tx_dc_d;
  logic [9:0]       fb_addr_q, fb_addr_d;
  logic             frame_done_q, frame_done_d;
  logic             oled_res_n_q, oled_res_n_d;
  logic             busy_q, busy_d;

  logic [4:0] rom_idx;
  logic [7:0] rom_byte;
  logic       xfer;

  // The ROM is addressed with the index of the byte about to be staged, so it
  // is decoded from current state only and stays out of the main next-state block.
  always_comb begin
    rom_idx = cmd_idx_q + 5'd1;
    if (state_q == RES_WAIT) begin
      rom_idx = '0;
    end else if (state_q == IDLE) begin
      rom_idx = 5'(INIT_LEN);
    end
  end

  oled_cmd_rom u_cmd_rom (
    .idx  (rom_idx),
    .data (rom_byte)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cmd_idx_d    = cmd_idx_q;
    data_idx_d   = data_idx_q;
    pending_d    = pending_q;
    tx_valid_d   = tx_valid_q;
    tx_byte_d    = tx_byte_q;
    tx_dc_d      = tx_dc_q;
    fb_addr_d    = fb_addr_q;
    frame_done_d = 1'b0;
    xfer         = tx_valid_q && tx_ready;

    if (frame_req && (state_q != IDLE)) begin
      pending_d = 1'b1;
    end

    case (state_q)
      RES_HOLD: begin
        if (cnt_q == CNT_W'(RES_LOW_CYC - 1)) begin
          state_d = RES_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RES_WAIT: begin
        if (cnt_q == CNT_W'(RES_WAIT_CYC - 1)) begin
          state_d    = INIT;
          cnt_d      = '0;
          cmd_idx_d  = '0;
          tx_byte_d  = rom_byte;
          tx_dc_d    = 1'b0;
          tx_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      INIT: begin
        if (xfer) begin
          if (cmd_idx_q == 5'(INIT_LEN - 1)) begin
            state_d    = IDLE;
            tx_valid_d = 1'b0;
          end else begin
            cmd_idx_d = cmd_idx_q + 5'd1;
            tx_byte_d = rom_byte;
          end
        end
      end
      IDLE: begin
        if (frame_req || pending_q) begin
          state_d    = ADDR;
          pending_d  = 1'b0;
          cmd_idx_d  = 5'(INIT_LEN);
          tx_byte_d  = rom_byte;
          tx_dc_d    = 1'b0;
          tx_valid_d = 1'b1;
        end
      end
      ADDR: begin
        if (xfer) begin
          if (cmd_idx_q == 5'(CMD_LEN - 1)) begin
            state_d    = FETCH;
            tx_valid_d = 1'b0;
            data_idx_d = '0;
            fb_addr_d  = '0;
          end else begin
            cmd_idx_d = cmd_idx_q + 5'd1;
            tx_byte_d = rom_byte;
          end
        end
      end
      FETCH: begin
        state_d = LOAD;
      end
      LOAD: begin
        state_d    = SEND;
        tx_byte_d  = fb_data;
        tx_dc_d    = 1'b1;
        tx_valid_d = 1'b1;
      end
      SEND: begin
        if (xfer) begin
          tx_valid_d = 1'b0;
          if (data_idx_q == 10'(FB_BYTES - 1)) begin
            state_d      = DONE;
            data_idx_d   = '0;
            frame_done_d = 1'b1;
          end else begin
            state_d    = FETCH;
            data_idx_d = data_idx_q + 10'd1;
            fb_addr_d  = data_idx_q + 10'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = RES_HOLD;
      end
    endcase

    oled_res_n_d = (state_d != RES_HOLD);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RES_HOLD;
      cnt_q        <= '0;
      cmd_idx_q    <= '0;
      data_idx_q   <= '0;
      pending_q    <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_byte_q    <= '0;
      tx_dc_q      <= 1'b0;
      fb_addr_q    <= '0;
      frame_done_q <= 1'b0;
      oled_res_n_q <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cmd_idx_q    <= cmd_idx_d;
      data_idx_q   <= data_idx_d;
      pending_q    <= pending_d;
      tx_valid_q   <= tx_valid_d;
      tx_byte_q    <= tx_byte_d;
      tx_dc_q      <= tx_dc_d;
      fb_addr_q    <= fb_addr_d;
      frame_done_q <= frame_done_d;
      oled_res_n_q <= oled_res_n_d;
      busy_q       <= busy_d;
    end
  end

  assign fb_addr    = fb_addr_q;
  assign tx_byte    = tx_byte_q;
  assign tx_dc      = tx_dc_q;
  assign tx_valid   = tx_valid_q;
  assign oled_res_n = oled_res_n_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_oled_seq.sv
// Bench for oled_seq: reset-phase vector table, transfer scoreboard, and
// hand-written sequences for stalls, queued requests and mid-frame reset.
module tb_oled_seq;

  logic       clk = 1'b0;
  logic       rst_n, frame_req, tx_ready;
  logic [9:0] fb_addr;
  logic [7:0] fb_data, tx_byte;
  logic       tx_dc, tx_valid, oled_res_n, busy, frame_done;

  int tests_run    = 0;
  int tests_failed = 0;
  int done_cnt     = 0;

  logic [8:0] exp_q [$];
  bit         mon_en = 1'b0;
  logic       prev_stall = 1'b0;
  logic [8:0] prev_word = '0;
  logic       rst_seen;

  logic [7:0] init_bytes [25] = '{
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
    8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
    8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
  };
  logic [7:0] addr_bytes [6] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};

  typedef struct {
    logic       rst_n;
    logic       exp_res_n;
    logic       exp_valid;
    logic [7:0] exp_byte;
    logic       exp_busy;
  } vec_t;

  always #5 clk = ~clk;

  oled_seq #(
    .RES_LOW_CYC  (4),
    .RES_WAIT_CYC (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_req  (frame_req),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .tx_byte    (tx_byte),
    .tx_dc      (tx_dc),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .oled_res_n (oled_res_n),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // Framebuffer model with one-cycle read latency; content is the low address byte.
  always @(posedge clk) fb_data <= fb_addr[7:0];
  always @(posedge clk) rst_seen <= !rst_n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_init();
    for (int i = 0; i < 25; i++) exp_q.push_back({1'b0, init_bytes[i]});
  endtask

  task automatic push_frame();
    for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, addr_bytes[i]});
    for (int i = 0; i < 1024; i++) exp_q.push_back({1'b1, 8'(i)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_req();
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max);
    int n = 0;
    while (frame_done !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    check({name, "_frame_done"}, 32'(frame_done), 32'd1);
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    while (busy !== 1'b0 && n < max) begin
      tick();
      n++;
    end
    check({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  // Transfer monitor: every accepted byte is popped from the scoreboard; a stall
  // must keep the presented word and valid unchanged into the next cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_stall === 1'b1 && rst_seen === 1'b0) begin
        check("hold_valid", 32'(tx_valid), 32'd1);
        check("hold_word", 32'({tx_dc, tx_byte}), 32'(prev_word));
      end
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_tx: got 0x%0h, required no transfer (t=%0t)",
                   {tx_dc, tx_byte}, $time);
        end else begin
          check("tx_word", 32'({tx_dc, tx_byte}), 32'(exp_q.pop_front()));
        end
      end
      prev_stall = (tx_valid === 1'b1) && (tx_ready === 1'b0);
      prev_word  = {tx_dc, tx_byte};
      if (frame_done === 1'b1) done_cnt++;
    end
  end

  initial begin
    vec_t vecs [10];
    int   n;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 8'hAE, 1'b1};
    vecs[9] = '{1'b1, 1'b1, 1'b1, 8'hD5, 1'b1};

    rst_n     = 1'b0;
    frame_req = 1'b0;
    tx_ready  = 1'b1;
    push_init();
    mon_en = 1'b1;

    for (int i = 0; i < 10; i++) begin
      rst_n = vecs[i].rst_n;
      tick();
      check($sformatf("vec%0d_res_n", i), 32'(oled_res_n), 32'(vecs[i].exp_res_n));
      check($sformatf("vec%0d_valid", i), 32'(tx_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_byte", i), 32'(tx_byte), 32'(vecs[i].exp_byte));
      check($sformatf("vec%0d_dc", i), 32'(tx_dc), 32'd0);
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      if (i < 2) begin
        check($sformatf("vec%0d_fb_addr", i), 32'(fb_addr), 32'd0);
        check($sformatf("vec%0d_frame_done", i), 32'(frame_done), 32'd0);
      end
    end

    wait_idle("init", 100);
    check("init_drained", 32'(exp_q.size()), 32'd0);

    // Frame 1: plain frame with the link always ready.
    push_frame();
    pulse_req();
    wait_done("frame1", 4000);
    wait_idle("frame1", 10);
    check("frame1_drained", 32'(exp_q.size()), 32'd0);
    repeat (5) tick();
    check("fb_addr_hold", 32'(fb_addr), 32'd1023);
    check("idle_no_valid", 32'(tx_valid), 32'd0);

    // Frame 2: stall on data byte 5, then three requests while busy.
    push_frame();
    pulse_req();
    n = 0;
    while (!(tx_valid === 1'b1 && tx_dc === 1'b1 && tx_byte === 8'h05) && n < 200) begin
      tick();
      n++;
    end
    check("stall_byte_found", 32'(tx_byte), 32'h05);
    tx_ready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      tick();
      check("stall_valid", 32'(tx_valid), 32'd1);
      check("stall_byte", 32'(tx_byte), 32'h05);
      check("stall_dc", 32'(tx_dc), 32'd1);
    end
    tx_ready = 1'b1;
    for (int p = 0; p < 3; p++) begin
      repeat (10) tick();
      pulse_req();
    end
    push_frame();
    wait_done("frame2", 4000);
    tick();
    check("gap2_busy", 32'(busy), 32'd0);
    check("gap2_valid", 32'(tx_valid), 32'd0);
    tick();
    check("restart2_valid", 32'(tx_valid), 32'd1);
    check("restart2_word", 32'({tx_dc, tx_byte}), 32'h021);

    // Frame 3: a request landing in the DONE cycle queues frame 4.
    wait_done("frame3", 4000);
    frame_req = 1'b1;
    push_frame();
    tick();
    frame_req = 1'b0;
    check("gap3_busy", 32'(busy), 32'd0);
    tick();
    check("restart3_valid", 32'(tx_valid), 32'd1);
    check("restart3_word", 32'({tx_dc, tx_byte}), 32'h021);

    // Frame 4: abort with reset while byte 300 is presented.
    n = 0;
    while (!(tx_valid === 1'b1 && tx_dc === 1'b1 && fb_addr === 10'd300) && n < 2000) begin
      tick();
      n++;
    end
    check("byte300_addr", 32'(fb_addr), 32'd300);
    check("byte300_data", 32'(tx_byte), 32'h2C);
    rst_n    = 1'b0;
    tx_ready = 1'b0;
    exp_q.delete();
    push_init();
    tick();
    rst_n    = 1'b1;
    tx_ready = 1'b1;
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_res_n", 32'(oled_res_n), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_byte", 32'(tx_byte), 32'd0);
    check("rst_fb_addr", 32'(fb_addr), 32'd0);
    n = 0;
    while (oled_res_n !== 1'b1 && n < 50) begin
      n++;
      tick();
    end
    check("res_low_cycles", 32'(n), 32'd4);

    // Request during RES_WAIT runs right after init completes.
    push_frame();
    pulse_req();
    wait_done("frame5", 5000);
    wait_idle("frame5", 10);
    repeat (20) tick();
    check("final_busy", 32'(busy), 32'd0);
    check("final_valid", 32'(tx_valid), 32'd0);
    check("final_drained", 32'(exp_q.size()), 32'd0);
    check("frame_done_count", 32'(done_cnt), 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/oled_seq.md
OLED_SEQ -- requirements
Module: oled_seq

Interface
REQ-001 Parameter RES_LOW_CYC, default 250, is the number of cycles oled_res_n is held low after reset.
REQ-002 Parameter RES_WAIT_CYC, default 250, is the number of cycles to wait after oled_res_n rises, before the first command.
REQ-003 clk  input  1  single system clock; every register is on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 frame_req  input  1  single-cycle request to send one full frame.
REQ-006 fb_addr  output  10  framebuffer read address (page*128 + column).
REQ-007 fb_data  input  8  framebuffer byte for the fb_addr of the previous cycle (1-cycle read latency).
REQ-008 tx_byte  output  8  byte to the downstream SPI byte transmitter.
REQ-009 tx_dc  output  1  0 = command byte, 1 = display-data byte; qualified by tx_valid.
REQ-010 tx_valid  output  1  tx_byte/tx_dc hold a byte to send.
REQ-011 tx_ready  input  1  downstream accepts the byte this cycle.
REQ-012 oled_res_n  output  1  panel hardware reset, active-low.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 frame_done  output  1  one-cycle pulse after the last data byte of a frame is accepted.

Function
REQ-015 States: RES_HOLD, RES_WAIT, INIT, IDLE, ADDR, FETCH, LOAD, SEND, DONE.
REQ-016 RES_HOLD: oled_res_n=0 for exactly RES_LOW_CYC cycles, then go to RES_WAIT.
REQ-017 RES_WAIT: oled_res_n=1 for exactly RES_WAIT_CYC cycles, then go to INIT; oled_res_n stays 1 in every state except RES_HOLD.
REQ-018 INIT: send INIT_LEN=25 bytes from INIT_ROM in index order with tx_dc=0, then go to IDLE.
REQ-019 Transfer rule: a byte transfers in a cycle with tx_valid=1 and tx_ready=1.
REQ-020 Hold rule: while tx_valid=1 and tx_ready=0, tx_byte and tx_dc hold stable and tx_valid stays 1.
REQ-021 After each transfer, tx_valid drops the next cycle unless the next byte is already staged; a command byte follows a command byte back-to-back.
REQ-022 IDLE: on frame_req=1, go to ADDR.
REQ-023 ADDR: send the 6 command bytes of ADDR_SEQ (0x21,0x00,0x7F,0x22,0x00,0x07) with tx_dc=0.
REQ-024 Data phase: for i=0..1023, FETCH drives fb_addr=i; LOAD captures fb_data into tx_byte with tx_dc=1 and tx_valid=1; SEND waits for the transfer, then returns to FETCH with i+1.
REQ-025 After byte 1023 transfers, the FSM goes to DONE, pulses frame_done for one cycle, and returns to IDLE.
REQ-026 The 10-bit data counter wraps only on the 1023→done transition; i is never reused within a frame.
REQ-027 A frame_req that arrives while busy=1 sets a one-deep pending flag.
REQ-028 On entering IDLE with the pending flag set, the FSM goes to ADDR on the next cycle and clears the flag; extra requests while pending are dropped.
REQ-029 A frame_req coinciding with the DONE cycle sets the pending flag.
REQ-030 A frame_req during RES_HOLD, RES_WAIT or INIT also sets the pending flag.
REQ-031 fb_addr holds its last value outside FETCH/LOAD.
REQ-032 A change on fb_data outside LOAD is ignored.

Reset
REQ-033 While rst_n=0 at a clock edge: state=RES_HOLD, counters=0, pending=0, tx_valid=0, tx_byte=0x00, tx_dc=0, fb_addr=0, frame_done=0, oled_res_n=0, busy=1.
REQ-034 Reset asserted mid-frame or mid-transfer aborts immediately: no partial byte is re-presented, and the full RES_HOLD/RES_WAIT/INIT sequence reruns.

Structure
REQ-035 Package oled_pkg holds: the state enum; INIT_LEN; INIT_ROM (AE,D5,80,A8,3F,D3,00,40,8D,14,20,00,A1,C8,DA,12,81,CF,D9,F1,DB,40,A4,A6,AF); ADDR_SEQ; FB_BYTES=1024.
REQ-036 One sub-module, oled_cmd_rom: combinational index→byte lookup over INIT_ROM followed by ADDR_SEQ (indices 0..30).
REQ-037 All other logic is flat in oled_seq.

Verification
REQ-038 RES_LOW_CYC=4, RES_WAIT_CYC=3, tx_ready=1 → oled_res_n=0 for 4 cycles then 1; first tx_valid 3 cycles later with tx_byte=0xAE, tx_dc=0.
REQ-039 tx_ready=1 continuously → 25 init bytes matching INIT_ROM, all with tx_dc=0, then busy=0.
REQ-040 fb_data=fb_addr[7:0], frame_req pulse → 6 ADDR_SEQ bytes with tx_dc=0, then 1024 bytes 0x00..0xFF repeating with tx_dc=1, then a single frame_done pulse.
REQ-041 tx_ready held 0 for 7 cycles on data byte 5 → tx_byte=0x05 and tx_valid=1 stable throughout; the byte transfers exactly once.
REQ-042 frame_req pulsed 3 times during a frame → exactly one more frame follows; the second frame starts with 0x21 one cycle after IDLE is entered.
REQ-043 rst_n low for 1 cycle at data byte 300 → tx_valid=0 and oled_res_n=0 the next cycle; the full reset and init sequence repeats.
